// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-port and line-fill bus of the direct-mapped instruction cache.
interface icache_dm_if #(parameter int ADDR_W = 16);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_oe;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic              flush;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_ack;
    logic              fill_valid;
    logic [31:0]       fill_data;

    modport master (
        output imem_addr, imem_oe, flush, fill_ack, fill_valid, fill_data,
        input  imem_rdata, imem_ready, fill_req, fill_addr
    );

    modport slave (
        input  imem_addr, imem_oe, flush, fill_ack, fill_valid, fill_data,
        output imem_rdata, imem_ready, fill_req, fill_addr
    );
endinterface

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache; one-cycle hits, whole-line fill on miss.
module icache_dm #(
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input logic         clk,
    input logic         rst_n,
    icache_dm_if.slave  bus
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-3:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     fill_addr_q, fill_addr_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic                  valid_rd_q, valid_rd_d;
    logic                  fill_req_q, fill_req_d;
    logic                  acked_q, acked_d;
    logic                  abort_q, abort_d;
    logic [OFF_W-1:0]      beat_q, beat_d;
    logic [31:0]           resp_q, resp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           data_rd_q;
    logic [TAG_W-1:0]      tag_rd_q;
    logic [TAG_W-1:0]      tag_mem [NUM_LINES];
    logic [31:0]           data_mem [NUM_LINES*LINE_WORDS];

    logic [OFF_W-1:0] req_off, lat_off;
    logic [IDX_W-1:0] req_idx, lat_idx;
    logic [TAG_W-1:0] lat_tag;
    logic             hit, accept, beat, last;

    assign req_off = bus.imem_addr[OFF_W+1:2];
    assign req_idx = bus.imem_addr[OFF_W+2 +: IDX_W];
    assign lat_off = addr_q[OFF_W-1:0];
    assign lat_idx = addr_q[OFF_W +: IDX_W];
    assign lat_tag = addr_q[ADDR_W-3 -: TAG_W];

    assign hit    = state_q == LOOKUP && valid_rd_q && tag_rd_q == lat_tag;
    assign accept = bus.imem_oe && (state_q == IDLE || state_q == RESP || hit);
    assign beat   = state_q == FILL && acked_q && bus.fill_valid;
    assign last   = beat && &beat_q;

    assign bus.imem_ready = state_q != FILL && !(state_q == LOOKUP && !hit);
    assign bus.imem_rdata = hit ? data_rd_q : state_q == RESP ? resp_q : rdata_q;
    assign bus.fill_req   = fill_req_q;
    assign bus.fill_addr  = fill_addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = accept ? bus.imem_addr[ADDR_W-1:2] : addr_q;
        valid_rd_d  = accept ? valid_q[req_idx] : valid_rd_q;
        valid_d     = bus.flush ? '0 : valid_q;
        fill_req_d  = fill_req_q;
        fill_addr_d = fill_addr_q;
        acked_d     = acked_q;
        abort_d     = abort_q;
        beat_d      = beat_q;
        resp_d      = resp_q;
        rdata_d     = bus.imem_rdata;
        case (state_q)
            IDLE:   state_d = accept ? LOOKUP : IDLE;
            LOOKUP: begin
                if (hit) begin
                    state_d = accept ? LOOKUP : IDLE;
                end else begin
                    state_d     = FILL;
                    fill_req_d  = 1'b1;
                    fill_addr_d = {addr_q[ADDR_W-3:OFF_W], {(OFF_W+2){1'b0}}};
                    acked_d     = 1'b0;
                end
            end
            FILL: begin
                abort_d = abort_q || bus.flush;
                if (fill_req_q && bus.fill_ack) begin
                    fill_req_d = 1'b0;
                    acked_d    = 1'b1;
                end
                if (beat) begin
                    beat_d = beat_q + OFF_W'(1);
                    resp_d = beat_q == lat_off ? bus.fill_data : resp_q;
                end
                // A flush seen at any point of the fill keeps the new line invalid
                if (last) begin
                    state_d = RESP;
                    acked_d = 1'b0;
                    valid_d[lat_idx] = !(abort_q || bus.flush);
                end
            end
            default: begin
                abort_d = 1'b0;
                state_d = accept ? LOOKUP : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            fill_addr_q <= '0;
            valid_q     <= '0;
            valid_rd_q  <= 1'b0;
            fill_req_q  <= 1'b0;
            acked_q     <= 1'b0;
            abort_q     <= 1'b0;
            beat_q      <= '0;
            resp_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            fill_addr_q <= fill_addr_d;
            valid_q     <= valid_d;
            valid_rd_q  <= valid_rd_d;
            fill_req_q  <= fill_req_d;
            acked_q     <= acked_d;
            abort_q     <= abort_d;
            beat_q      <= beat_d;
            resp_q      <= resp_d;
            rdata_q     <= rdata_d;
        end
    end

    // Arrays carry no reset; only the valid bits decide whether their contents count
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_rd_q  <= tag_mem[req_idx];
            data_rd_q <= data_mem[{req_idx, req_off}];
        end
        if (beat) data_mem[{lat_idx, beat_q}] <= bus.fill_data;
        if (last) tag_mem[lat_idx] <= lat_tag;
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the processor's instruction-fetch port (imem_*) and a slower backing instruction memory (fill_*).
- Hits return data the cycle after the request, with no stall.
- On a miss it drops imem_ready, fills the whole line, then returns the requested word.
- flush invalidates all lines; it is driven by fence.i or by debug logic.

Parameters:
- ADDR_W, 16, byte address width of imem_addr and fill_addr.
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- NUM_LINES, 64, number of lines (power of 2). Tag width = ADDR_W-2-log2(LINE_WORDS)-log2(NUM_LINES), which is 6 with the defaults.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imem_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored
- imem_oe  in  1  fetch request, sampled each cycle
- imem_rdata  out  32  fetched instruction
- imem_ready  out  1  qualifies imem_rdata for the request made in the previous accepted cycle
- flush  in  1  invalidate all lines
- fill_req  out  1  line-fill request, held until fill_ack
- fill_addr  out  ADDR_W  line-aligned byte address of the fill
- fill_ack  in  1  backing memory accepted the request
- fill_valid  in  1  one fill beat present
- fill_data  in  32  fill beat data; beats arrive in ascending word order

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, all valid bits cleared, fill_req=0, fill_addr=0.
  - imem_ready=1, imem_rdata=0, beat counter=0.
  - Reset mid-fill abandons the fill. Any fill beats arriving afterwards are ignored.
- States: IDLE, LOOKUP, FILL, RESP.
- Request acceptance: imem_oe is honoured only in IDLE, LOOKUP-hit and RESP cycles. It is ignored in FILL and in a LOOKUP that misses; the requester holds imem_oe low while stalled.
- Accepted request at cycle t:
  - The address is latched.
  - Tag RAM, data RAM and the valid bit are read synchronously.
  - The state enters LOOKUP at t+1.
- LOOKUP, hit (valid and tag match):
  - imem_ready=1 and imem_rdata=line word [addr bits] combinationally from the data RAM output at t+1.
  - A new imem_oe in this cycle is accepted, giving back-to-back hits at 1 instruction/cycle.
  - Next state is LOOKUP if oe, else IDLE.
- LOOKUP, miss:
  - imem_ready=0.
  - Next state is FILL; fill_req=1 and fill_addr={latched tag,index,0} are registered at t+2.
- FILL:
  - imem_ready=0.
  - fill_req drops the cycle after fill_ack is sampled high. fill_ack may be high in the first FILL cycle.
  - Each fill_valid beat is written into data RAM word [beat counter], and the counter increments.
  - The beat matching the requested word offset is also captured into the response register.
  - Gaps between beats are allowed, and fill_valid before fill_ack is ignored.
  - On the last beat (counter = LINE_WORDS-1): write the tag, set valid, counter←0, next state RESP.
- RESP (one cycle):
  - imem_ready=1 and imem_rdata=captured word.
  - A new imem_oe is accepted here.
  - Next state is LOOKUP if oe, else IDLE.
- IDLE: imem_ready=1 and imem_rdata holds its last value. The value is don't-care to the requester but stable.
- flush:
  - In IDLE, LOOKUP or RESP, all valid bits clear at the next edge.
  - A LOOKUP in the same cycle as flush still evaluates against the pre-flush valid bits.
  - flush during FILL sets a sticky abort flag. The fill completes and the word is returned in RESP, but the line's valid bit is left 0. The flag clears on RESP.
  - Simultaneous flush and the last beat behave like flush during FILL: the line stays invalid.
- Conflict: a fill overwrites the line at its index unconditionally. There is no write path, so no writeback.
- Index and word-offset arithmetic are pure bit slices of the address. No wrap handling is needed beyond ADDR_W truncation.

Test Plan:
- Cold miss, zero-wait memory:
  - Stimulus: oe at 0x0104 with cycle t.
  - Required: ready=0 at t+1; fill_req with fill_addr=0x0100 at t+2; ack at t+2; beats 0x11,0x22,0x33,0x44 at t+3..t+6.
  - Required: RESP at t+7 with ready=1, rdata=0x22.
- Hit stream: after the cold miss above, oe on 0x0100, 0x0104, 0x0108, 0x010C on consecutive cycles -> ready=1 every following cycle with rdata 0x11, 0x22, 0x33, 0x44; fill_req stays 0.
- Conflict eviction (defaults): fetch 0x0100, then 0x0500 (same index, tag 1), then 0x0100 -> three misses, each issuing fill_req with fill_addr 0x0100, 0x0500, 0x0100 respectively.
- Gapped fill with late ack: ack 3 cycles after fill_req and one idle cycle between each beat -> ready stays 0 throughout FILL, then exactly one RESP cycle with the correct word; fill_valid pulses before ack do not corrupt the line.
- Flush:
  - Flush in IDLE after the line at 0x0100 is filled -> the next fetch of 0x0100 misses.
  - Flush asserted mid-FILL -> the requested word is still returned, and the immediate re-fetch misses again.
- Reset mid-fill: pull rst_n low after 2 of 4 beats -> outputs go to reset values immediately (ready=1, fill_req=0); the refetch of the same address after release misses and refills fully.
